// File: rtl/results_sender_gen_if.sv
// Ready/valid beat bus between the result streamer and the CPU-side wrapper.
// Bus_OE mirrors Bus_Valid and drives the wrapper's tristate.
interface results_sender_gen_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] Bus_Out;
  logic                 Bus_Valid;
  logic                 Bus_OE;
  logic                 Bus_Ready;

  modport master (
    output Bus_Out,
    output Bus_Valid,
    output Bus_OE,
    input  Bus_Ready
  );

  modport slave (
    input  Bus_Out,
    input  Bus_Valid,
    input  Bus_OE,
    output Bus_Ready
  );
endinterface

// File: rtl/results_sender_gen.sv
// Streams N solver results from a dual-read-port RAM, a pair per fetch, as
// BUS_WIDTH beats on a ready/valid bus, optionally preceded by a count header.
module results_sender_gen #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int BUS_WIDTH     = 32,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic                     Header_Enable,
  input  logic [ADDRESS_WIDTH-1:0] Result_Count,
  results_sender_gen_if.master     bus,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
  input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A,
  input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B,
  output logic                     Busy,
  output logic                     Done_Sending
);

  localparam int BEATS  = DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_B = ADDRESS_WIDTH'(BASE_ADDR + 1);
  localparam logic [ADDRESS_WIDTH:0]   ONE    = 1;
  localparam logic [ADDRESS_WIDTH:0]   TWO    = 2;

  typedef enum logic [2:0] {
    IDLE, HEADER, FETCH, LOAD, SEND_A, SEND_B, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0]          n_reg;
  logic [ADDRESS_WIDTH:0]            sent;
  logic [BEAT_W-1:0]                 beat;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   hold_a;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   hold_b;
  logic [ADDRESS_WIDTH-1:0]          addr_a;
  logic [ADDRESS_WIDTH-1:0]          addr_b;

  logic                 last_beat;
  logic                 b_remains;
  logic                 pair_remains;
  logic [BUS_WIDTH-1:0] bus_out;
  logic                 bus_valid;

  // sent is one bit wider than N so sent+2 cannot wrap on the final pair.
  assign last_beat    = (beat == BEAT_W'(BEATS - 1));
  assign b_remains    = (sent + ONE) < {1'b0, n_reg};
  assign pair_remains = (sent + TWO) < {1'b0, n_reg};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (Start) begin
        if (Header_Enable)          state_next = HEADER;
        else if (Result_Count != 0) state_next = FETCH;
        else                        state_next = DONE;
      end
      HEADER: if (bus.Bus_Ready) state_next = (n_reg != 0) ? FETCH : DONE;
      FETCH:  state_next = LOAD;
      LOAD:   state_next = SEND_A;
      SEND_A: if (bus.Bus_Ready && last_beat) state_next = b_remains ? SEND_B : DONE;
      SEND_B: if (bus.Bus_Ready && last_beat) state_next = pair_remains ? FETCH : DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the hold registers are reset too, so Bus_Out can never show data
  // left over from a transfer that reset aborted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_reg  <= '0;
      sent   <= '0;
      beat   <= '0;
      hold_a <= '0;
      hold_b <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      unique case (state)
        IDLE: if (Start) begin
          n_reg  <= Result_Count;
          addr_a <= BASE_A;
          addr_b <= BASE_B;
          sent   <= '0;
        end
        LOAD: begin
          hold_a <= RAM_Data_RD_A;
          hold_b <= RAM_Data_RD_B;
          beat   <= '0;
        end
        SEND_A: if (bus.Bus_Ready) beat <= last_beat ? '0 : beat + 1'b1;
        SEND_B: if (bus.Bus_Ready) begin
          if (last_beat) begin
            beat   <= '0;
            sent   <= sent + TWO;
            addr_a <= addr_a + ADDRESS_WIDTH'(2);
            addr_b <= addr_b + ADDRESS_WIDTH'(2);
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so they are stable for the whole cycle.
  always_comb begin
    bus_out   = '0;
    bus_valid = 1'b0;
    unique case (state)
      HEADER: begin
        bus_out   = BUS_WIDTH'(n_reg);
        bus_valid = 1'b1;
      end
      SEND_A: begin
        bus_out   = hold_a[beat];
        bus_valid = 1'b1;
      end
      SEND_B: begin
        bus_out   = hold_b[beat];
        bus_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Bus_Out       = bus_out;
  assign bus.Bus_Valid     = bus_valid;
  assign bus.Bus_OE        = bus_valid;
  assign Busy              = (state != IDLE);
  assign Done_Sending      = (state == DONE);
  assign RAM_Address_RD_A  = addr_a;
  assign RAM_Address_RD_B  = addr_b;

endmodule

// File: doc/results_sender_gen.md
# results_sender_gen

Parametrised result streamer for the IO path. On a start request it reads a programmable number of DATA_WIDTH-bit results from the solver RAM through both read ports, a pair at a time. It serialises each result into BUS_WIDTH-bit beats on a ready/valid handshake toward the CPU bus, optionally preceded by a count header. It generalises the fixed 64-to-32 sender with configurable widths, base address and result count, plus backpressure support.

## Interface
- ADDRESS_WIDTH, 13, RAM address width; also the width of Result_Count
- DATA_WIDTH, 64, RAM word width; must be an integer multiple of BUS_WIDTH
- BUS_WIDTH, 32, CPU bus beat width; must be ≥ ADDRESS_WIDTH
- BASE_ADDR, 0, RAM address of result 0

- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous reset, active-high
- Start  in  1  begin transfer; sampled only in IDLE
- Header_Enable  in  1  sampled with Start; 1 = send count header beat first
- Result_Count  in  ADDRESS_WIDTH  number of results N; sampled with Start
- Bus_Ready  in  1  CPU accepts the current beat
- Bus_Out  out  BUS_WIDTH  beat data; 0 when Bus_Valid=0
- Bus_Valid  out  1  beat present
- Bus_OE  out  1  tristate enable for the wrapper; equals Bus_Valid
- RAM_Address_RD_A  out  ADDRESS_WIDTH  even-result read address
- RAM_Address_RD_B  out  ADDRESS_WIDTH  odd-result read address
- RAM_Data_RD_A  in  DATA_WIDTH  port A read data; valid one cycle after address is stable
- RAM_Data_RD_B  in  DATA_WIDTH  port B read data; same timing as port A
- Busy  out  1  high in every state except IDLE
- Done_Sending  out  1  one-cycle pulse at end of transfer

## Operation
- BEATS = DATA_WIDTH/BUS_WIDTH.
- States: IDLE, HEADER, FETCH, LOAD, SEND_A, SEND_B, DONE.
- IDLE, Start=1: latch N and Header_Enable, set addr A=BASE_ADDR and B=BASE_ADDR+1, clear the sent counter. Next state: HEADER if header enabled, else FETCH if N>0, else DONE.
- HEADER: Bus_Out = N zero-extended. On Valid&&Ready, go to FETCH if N>0, else DONE.
- FETCH: addresses stable; RAM access in progress; always advances to LOAD.
- LOAD: capture RAM_Data_RD_A/B into hold registers, clear beat index, go to SEND_A.
- SEND_A / SEND_B: Bus_Out = slice [beat*BUS_WIDTH +: BUS_WIDTH] of the held word, least significant slice first. The beat index advances only on Valid&&Ready.
- After the last beat of A: go to SEND_B if a B result remains (sent+1 < N), else DONE.
- After the last beat of B: sent += 2 and addresses += 2. Go to FETCH if sent < N, else DONE.
- Odd N: the final pair sends A only; B data is read but discarded.
- DONE: Done_Sending=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDRESS_WIDTH (wraps past the top address).
- Start outside IDLE is ignored. Result_Count and Header_Enable changes after sampling are ignored.
- Reset values: all outputs 0, state IDLE, hold registers 0.

## Timing
- Cycle k = the k-th cycle after the edge that samples Start in IDLE.
- No header: FETCH in cycle 1, LOAD in cycle 2, first Bus_Valid in cycle 3.
- With header: header beat valid from cycle 1; FETCH follows the header handshake cycle.
- Handshake: Bus_Out and Bus_Valid are registered and held stable until Valid&&Ready is sampled. The next beat (if any) is valid in the following cycle, with no bubble within a word.
- Per pair with Bus_Ready held high: 2 + 2*BEATS cycles. Per final odd result: 2 + BEATS cycles.
- Done_Sending goes high in the cycle after the last accepted beat; Busy drops the cycle after that.
- A Start sampled in the same cycle as Done_Sending is ignored.
- RST=1 at any edge: the next cycle is IDLE with all outputs 0. An in-flight beat is dropped and no Done_Sending pulse is produced.

## Test plan
- N=0, Header_Enable=1, Ready=1 -> one beat Bus_Out=0x00000000 in cycle 1, Done_Sending in cycle 2, no RAM-data beats.
- N=4, no header, RAM[i]=0x1111_0000_0000_0000*(i+1)+i, Ready=1 -> 8 beats, low half first. Beats arrive in cycles 3,4,5,6 and 9,10,11,12. Done_Sending in cycle 13.
- N=3, header on -> header 0x00000003, then 6 data beats (results 0,1,2); result 3 is never sent; addresses reach BASE+2/BASE+3.
- Backpressure: N=2, Ready low on alternate cycles -> each beat is held unchanged until accepted; 4 beats total, in order; no loss or duplication.
- Wrap: BASE_ADDR=8190, N=4 -> read addresses 8190/8191, then 0/1.
- RST asserted during SEND_B of the first pair, then a new Start with N=1 -> outputs 0 the cycle after reset, no Done pulse. The new transfer sends result 0 normally, followed by a single Done pulse.
